watchdog_core: RTL
==================

WATCHDOG_CORE -- requirements
Module: watchdog_core

Interface
REQ-001 SHALL have parameter KICK_KEY, default 16'hD09F, meaning the only kick key value that restarts the timer.
REQ-002 SHALL have parameter CNT_W, default 32, meaning the width of the timeout counter.
REQ-003 SHALL have port clk  input  1  project clock, nominally 64 MHz.
REQ-004 SHALL have port rst  input  1  one clock; reset is synchronous and active-high.
REQ-005 SHALL have port cfg_timeout  input  CNT_W  first-stage reload value, held by the register front end.
REQ-006 SHALL have port cfg_window  input  16  second-stage (bark-to-bite) reload value.
REQ-007 SHALL have port cfg_prescale  input  8  tick divider; a tick occurs every cfg_prescale+1 cycles.
REQ-008 SHALL have port enable_pulse  input  1  start request, one cycle.
REQ-009 SHALL have port disable_pulse  input  1  stop request, one cycle.
REQ-010 SHALL have port kick_valid  input  1  kick strobe, one cycle.
REQ-011 SHALL have port kick_key  input  16  key accompanying kick_valid.
REQ-012 SHALL have port irq_clear  input  1  clears irq, one cycle.
REQ-013 SHALL have port irq  output  1  bark interrupt, level, to user_interrupt.
REQ-014 SHALL have port bite  output  1  reset request, level, sticky.
REQ-015 SHALL have port state  output  2  current FSM state.
REQ-016 SHALL have port count  output  CNT_W  current counter value.
REQ-017 SHALL have port kick_err  output  1  sticky flag set by a wrong-key kick.

Function
REQ-018 SHALL implement the states DISABLED=0, RUNNING=1, BARKED=2 and BITTEN=3.
REQ-019 SHALL sample cfg_timeout and cfg_window only at reload events; input changes between reloads SHALL have no effect.
REQ-020 SHALL clear the prescaler on every reload and assert tick when the prescaler equals cfg_prescale, in RUNNING or BARKED only.
REQ-021 On a tick, SHALL produce an expiry event if count==0, else count-1; a reload of N therefore yields expiry after N+1 ticks, with no wrap below 0.
REQ-022 In DISABLED, enable_pulse SHALL load count<=cfg_timeout and move to RUNNING.
REQ-023 In RUNNING, expiry SHALL move to BARKED, set irq=1 and load count<=cfg_window (zero-extended).
REQ-024 In BARKED, expiry SHALL move to BITTEN and set bite=1.
REQ-025 In RUNNING or BARKED, kick_valid with kick_key==KICK_KEY SHALL load count<=cfg_timeout, clear irq and move to RUNNING.
REQ-026 kick_valid with any other key SHALL set kick_err and otherwise be ignored; kick_err SHALL clear only on rst.
REQ-027 In RUNNING or BARKED, disable_pulse SHALL move to DISABLED, clear irq and hold count.
REQ-028 irq_clear SHALL clear irq without a state change.
REQ-029 BITTEN SHALL be terminal: kick, enable and disable SHALL be ignored, and bite SHALL stay 1 until rst.
REQ-030 Priority SHALL be: disable over kick over expiry.
REQ-031 An irq set (bark) SHALL win over irq_clear in the same cycle.
REQ-032 enable_pulse outside DISABLED SHALL be ignored.
REQ-033 All outputs SHALL be registered, and state changes SHALL be visible the cycle after the triggering edge.

Reset
REQ-034 rst SHALL force state=DISABLED, count=0, prescaler=0, irq=0, bite=0 and kick_err=0 at the next clk edge, overriding all inputs, including mid-count and in BITTEN.

Structure
REQ-035 A package watchdog_pkg SHALL hold the state encoding and the KICK_KEY default.
REQ-036 One sub-module, watchdog_prescaler, SHALL hold the 8-bit divider with clear and tick output.
REQ-037 The block SHALL contain no bus decoding; the register front end drives the pulses and levels.

Verification
REQ-038 Bark then bite: prescale=0, timeout=3, window=2, enable at edge E -> irq=1 after E+4, count=2; bite=1 after E+7, state=3.
REQ-039 Good kick: same config, kick 16'hD09F at E+2 -> count=3 after E+3, no irq through E+6, irq after E+7.
REQ-040 Bad kick: kick key 16'h1234 in RUNNING -> kick_err=1, count continues decrementing, timing unchanged.
REQ-041 Prescale: prescale=3, timeout=1 -> count decrements every 4 cycles, irq 8 cycles after enable.
REQ-042 Priorities: disable+kick in the same cycle -> DISABLED; kick on the expiry cycle -> RUNNING with irq=0; irq_clear on the bark cycle -> irq=1.
REQ-043 Reset in BITTEN: assert rst one cycle -> all outputs 0 and state=0 next cycle; a subsequent enable runs normally.

Source files
------------

// File: rtl/watchdog_pkg.sv
// watchdog_pkg -- shared definitions for the watchdog core.
//   wd_state_e       : FSM state encoding, also driven out on the state port.
//   WD_KICK_KEY_DEF  : default kick key.
//   wd_is_active()   : true in the states where the timer counts.
package watchdog_pkg;

    typedef enum logic [1:0] {
        WD_DISABLED = 2'd0,
        WD_RUNNING  = 2'd1,
        WD_BARKED   = 2'd2,
        WD_BITTEN   = 2'd3
    } wd_state_e;

    localparam logic [15:0] WD_KICK_KEY_DEF = 16'hD09F;
    localparam int unsigned WD_PSC_W        = 8;

    // The timer only counts in RUNNING and BARKED.
    function automatic logic wd_is_active(input wd_state_e s);
        return (s == WD_RUNNING) || (s == WD_BARKED);
    endfunction

endpackage

// File: rtl/watchdog_prescaler.sv
// watchdog_prescaler -- 8-bit tick divider.
//   clk, rst     : clock, synchronous active-high reset
//   clr_i        : restart the divider (reload events)
//   run_i        : divider counts only while high; held at 0 otherwise
//   prescale_i   : terminal value; one tick every prescale_i+1 cycles
//   tick_o       : combinational tick, high on the terminal cycle
module watchdog_prescaler
    import watchdog_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_i,
    input  logic                run_i,
    input  logic [WD_PSC_W-1:0] prescale_i,
    output logic                tick_o
);

    logic [WD_PSC_W-1:0] cnt_q, cnt_d;

    assign tick_o = run_i && (cnt_q == prescale_i);

    // A tick wraps the divider; a clear or idle period parks it at zero so
    // the first tick after a reload lands a full period later.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || !run_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/watchdog_core.sv
// watchdog_core -- two-stage (bark/bite) watchdog timer.
//   clk, rst       : clock, synchronous active-high reset
//   cfg_timeout    : first-stage reload, sampled only at reload events
//   cfg_window     : bark-to-bite reload, sampled only at the bark
//   cfg_prescale   : tick every cfg_prescale+1 cycles
//   enable_pulse   : start from DISABLED
//   disable_pulse  : stop from RUNNING/BARKED (count is held)
//   kick_valid/key : restart request; wrong key sets kick_err
//   irq_clear      : clear the bark interrupt
//   irq, bite      : bark interrupt level, sticky reset request
//   state, count   : FSM state and live counter
//   kick_err       : sticky wrong-key flag, cleared only by rst
// All outputs come straight from flops.
module watchdog_core
    import watchdog_pkg::*;
#(
    parameter logic [15:0] KICK_KEY = WD_KICK_KEY_DEF,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cfg_timeout,
    input  logic [15:0]      cfg_window,
    input  logic [7:0]       cfg_prescale,
    input  logic             enable_pulse,
    input  logic             disable_pulse,
    input  logic             kick_valid,
    input  logic [15:0]      kick_key,
    input  logic             irq_clear,
    output logic             irq,
    output logic             bite,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] count,
    output logic             kick_err
);

    wd_state_e        state_q;
    logic [CNT_W-1:0] count_q;
    logic             irq_q, bite_q, kick_err_q;

    logic active, tick, key_ok, good_kick, bad_kick;
    logic do_enable, do_disable, do_kick, do_bark, psc_clr;

    assign active    = wd_is_active(state_q);
    assign key_ok    = (kick_key == KICK_KEY);
    assign good_kick = kick_valid && key_ok;
    assign bad_kick  = kick_valid && !key_ok && (state_q != WD_BITTEN);

    // Priority among active-state events: disable > kick > expiry.
    assign do_enable  = (state_q == WD_DISABLED) && enable_pulse;
    assign do_disable = active && disable_pulse;
    assign do_kick    = active && !disable_pulse && good_kick;
    assign do_bark    = (state_q == WD_RUNNING) && !disable_pulse && !good_kick
                        && tick && (count_q == '0);

    // Every reload restarts the divider; disable parks it as well.
    assign psc_clr = do_enable || do_disable || do_kick || do_bark;

    watchdog_prescaler u_psc (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (psc_clr),
        .run_i      (active),
        .prescale_i (cfg_prescale),
        .tick_o     (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= WD_DISABLED;
            count_q    <= '0;
            irq_q      <= 1'b0;
            bite_q     <= 1'b0;
            kick_err_q <= 1'b0;
        end else begin
            if (bad_kick) begin
                kick_err_q <= 1'b1;
            end
            // Default clear; a bark below overrides it in the same cycle.
            if (irq_clear) begin
                irq_q <= 1'b0;
            end
            case (state_q)
                WD_DISABLED: begin
                    if (enable_pulse) begin
                        state_q <= WD_RUNNING;
                        count_q <= cfg_timeout;
                    end
                end
                WD_RUNNING, WD_BARKED: begin
                    if (disable_pulse) begin
                        state_q <= WD_DISABLED;
                        irq_q   <= 1'b0;
                    end else if (good_kick) begin
                        state_q <= WD_RUNNING;
                        count_q <= cfg_timeout;
                        irq_q   <= 1'b0;
                    end else if (tick) begin
                        if (count_q == '0) begin
                            if (state_q == WD_RUNNING) begin
                                state_q <= WD_BARKED;
                                irq_q   <= 1'b1;
                                count_q <= CNT_W'(cfg_window);
                            end else begin
                                state_q <= WD_BITTEN;
                                bite_q  <= 1'b1;
                            end
                        end else begin
                            count_q <= count_q - 1'b1;
                        end
                    end
                end
                default: begin
                    // BITTEN is terminal until rst.
                end
            endcase
        end
    end

    assign irq      = irq_q;
    assign bite     = bite_q;
    assign state    = state_q;
    assign count    = count_q;
    assign kick_err = kick_err_q;

endmodule
